// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential packed-BCD adder/subtractor.
// Holds: digit width, controller state encoding, and digit helper functions
// (nines complement and the valid-digit test).
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nines complement of one decimal digit. Invalid digits wrap, but results
    // built from them are discarded because err forces the sum to zero.
    function automatic logic [BCD_W-1:0] nines(input logic [BCD_W-1:0] d);
        return 4'd9 - d;
    endfunction

    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single decimal digit adder with +6 correction, purely combinational.
// Ports: a, b (BCD digits), cin -> sum (BCD digit), cout (decimal carry).
// Zero latency; no handshake, chained by the parent to form one pass.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] t;

    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        sum  = t[BCD_W-1:0];
        cout = 1'b0;
        if (t > 5'd9) begin
            // Skip the six unused codes so the nibble wraps past 9 to 0.
            sum  = t[BCD_W-1:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Multi-cycle packed-BCD add/subtract, DPC digits per clock, LSD first.
// Ports: clk/reset, in_valid/in_ready + a, b, cin, sub; out_valid/out_ready +
// sum, cout, err. Latency NDIGITS/DPC cycles; outputs held until out_ready.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 100,
    parameter int DPC     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BCD_W*NDIGITS-1:0] a,
    input  logic [BCD_W*NDIGITS-1:0] b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BCD_W*NDIGITS-1:0] sum,
    output logic                     cout,
    output logic                     err
);

    localparam int W    = BCD_W * NDIGITS;
    localparam int PW   = BCD_W * DPC;
    localparam int NCYC = NDIGITS / DPC;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res_sh;
    logic [W-1:0]    res_next;
    logic            carry;
    logic            sub_r;
    logic            err_r;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pass_sum;
    logic [DPC:0]    chain;
    logic            in_err;
    logic            accept;

    // One pass: DPC corrected digit adders rippling from the registered carry.
    assign chain[0] = carry;

    for (genvar i = 0; i < DPC; i++) begin : g_dig
        logic [BCD_W-1:0] bd;
        assign bd = sub_r ? nines(b_sh[i*BCD_W +: BCD_W]) : b_sh[i*BCD_W +: BCD_W];

        bcd_digit_add u_dig (
            .a    (a_sh[i*BCD_W +: BCD_W]),
            .b    (bd),
            .cin  (chain[i]),
            .sum  (pass_sum[i*BCD_W +: BCD_W]),
            .cout (chain[i+1])
        );
    end

    // Result digits enter at the top so after NCYC passes the LSD is at bit 0.
    if (NCYC > 1) begin : g_res_multi
        assign res_next = {pass_sum, res_sh[W-1:PW]};
    end else begin : g_res_single
        assign res_next = pass_sum;
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!bcd_valid(a[i*BCD_W +: BCD_W]) || !bcd_valid(b[i*BCD_W +: BCD_W])) begin
                in_err = 1'b1;
            end
        end
    end

    // In DONE a new operand is only taken when the pending result leaves.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            sub_r     <= 1'b0;
            err_r     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
        end else begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                sub_r <= sub;
                // Subtraction is A + nines(B) + 1 - borrow_in.
                carry <= sub ? ~cin : cin;
                err_r <= in_err;
                cnt   <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> PW;
                    b_sh   <= b_sh >> PW;
                    res_sh <= res_next;
                    carry  <= chain[DPC];
                    if (cnt == CW'(NCYC - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= err_r ? '0 : res_next;
                        cout      <= err_r ? 1'b0 : chain[DPC];
                        err       <= err_r;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= in_valid ? RUN : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Bench for bcd_addsub_seq: a 4-digit/1-per-clock instance for directed
// corner cases and a default 100-digit/4-per-clock instance for random ops.
// Expected results are queued at accept and compared at the output handshake.
module tb_bcd_addsub_seq;

    typedef struct {
        logic [399:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [399:0] a = '0;
    logic [399:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [1:0]   in_valid = 2'b00;
    logic [1:0]   out_ready = 2'b11;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   cout;
    logic [1:0]   err;
    logic [15:0]  s_sum;
    logic [399:0] b_sum;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q [2][$];
    logic prev_ov [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_addsub_seq #(.NDIGITS(4), .DPC(1)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(s_sum), .cout(cout[0]), .err(err[0])
    );

    bcd_addsub_seq u_big (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(b_sum), .cout(cout[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Schoolbook decimal add / borrow-subtract on digit arrays.
    task automatic ref_model(input int n, input logic [399:0] av, input logic [399:0] bv,
                             input logic ci, input logic sb, output exp_t e);
        int c;
        int d;
        int da;
        int db;
        e.sum  = '0;
        e.err  = 1'b0;
        e.acc  = 0;
        c      = ci ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            da = int'(av[i*4 +: 4]);
            db = int'(bv[i*4 +: 4]);
            if (da > 9 || db > 9) e.err = 1'b1;
            if (sb) begin
                d = da - db - c;
                c = (d < 0) ? 1 : 0;
                if (d < 0) d += 10;
            end else begin
                d = da + db + c;
                c = (d >= 10) ? 1 : 0;
                if (d >= 10) d -= 10;
            end
            e.sum[i*4 +: 4] = d[3:0];
        end
        e.cout = sb ? (c == 0) : (c == 1);
        if (e.err) begin
            e.sum  = '0;
            e.cout = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int id, input logic [399:0] av, input logic [399:0] bv,
                        input logic ci, input logic sb, input logic push);
        exp_t e;
        logic rdy;
        ref_model((id == 0) ? 4 : 100, av, bv, ci, sb, e);
        a = av;
        b = bv;
        cin = ci;
        sub = sb;
        in_valid[id] = 1'b1;
        rdy = 1'b0;
        for (int t = 0; t < 300 && !rdy; t++) begin
            @(negedge clk);
            rdy = in_ready[id];
            @(posedge clk);
            #1;
        end
        in_valid[id] = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 1'b0, 1'b1);
        end else if (push) begin
            e.acc = cyc;
            q[id].push_back(e);
        end
    endtask

    task automatic drain(input int id);
        for (int t = 0; t < 400 && q[id].size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q[id].size(), 0);
    endtask

    task automatic mon(input int id, input logic ov, input logic ordy, input logic [399:0] s,
                       input logic co, input logic e, input int ncyc);
        exp_t x;
        if (ov && !prev_ov[id]) begin
            if (q[id].size() == 0) chk("spurious_valid", 1'b1, 1'b0);
            else chk("latency", cyc, q[id][0].acc + ncyc);
        end
        if (ov && ordy && q[id].size() != 0) begin
            x = q[id].pop_front();
            chk("sum", s, x.sum);
            chk("cout", co, x.cout);
            chk("err", e, x.err);
        end
        prev_ov[id] = ov;
    endtask

    always @(negedge clk) begin
        mon(0, out_valid[0], out_ready[0], {384'b0, s_sum}, cout[0], err[0], 4);
        mon(1, out_valid[1], out_ready[1], b_sum, cout[1], err[1], 25);
    end

    initial begin
        logic [15:0]  hs;
        logic         hc;
        logic [399:0] ra;
        logic [399:0] rb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_in_ready", in_ready, 2'b11);
        chk("rst_sum_s", s_sum, 0);
        chk("rst_sum_b", b_sum, 0);
        chk("rst_cout", cout, 2'b00);
        chk("rst_err", err, 2'b00);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed 4-digit cases.
        send(0, 400'h9999, 400'h0001, 1'b0, 1'b0, 1'b1);
        send(0, 400'h0100, 400'h0001, 1'b0, 1'b1, 1'b1);
        send(0, 400'h0001, 400'h0002, 1'b0, 1'b1, 1'b1);
        send(0, 400'h0005, 400'h0004, 1'b1, 1'b1, 1'b1);
        send(0, 400'h00A0, 400'h0001, 1'b0, 1'b0, 1'b1);
        send(0, 400'h0458, 400'h0999, 1'b1, 1'b0, 1'b1);
        drain(0);

        // Backpressure: result held stable, then same-cycle handoff.
        out_ready[0] = 1'b0;
        send(0, 400'h0012, 400'h0034, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 20 && !out_valid[0]; t++) @(negedge clk);
        chk("hold_valid_seen", out_valid[0], 1'b1);
        hs = s_sum;
        hc = cout[0];
        chk("hold_first_sum", s_sum, 16'h0046);
        repeat (3) begin
            @(negedge clk);
            chk("hold_sum", s_sum, hs);
            chk("hold_cout", cout[0], hc);
            chk("hold_valid", out_valid[0], 1'b1);
            chk("hold_in_ready", in_ready[0], 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, 400'h1234, 400'h4321, 1'b0, 1'b0, 1'b1);
        drain(0);

        // Reset two cycles into a run discards the operation.
        send(0, 400'h0011, 400'h0022, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_in_ready", in_ready[0], 1'b1);
        chk("midrst_out_valid", out_valid[0], 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_quiet", out_valid[0], 1'b0);
        send(0, 400'h0567, 400'h0289, 1'b0, 1'b1, 1'b1);
        drain(0);

        // Wide instance: carry through all 100 digits, then random traffic.
        ra = {100{4'h9}};
        send(1, ra, 400'h1, 1'b0, 1'b0, 1'b1);
        send(1, 400'h0, 400'h1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 100; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(0, 9));
                rb[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            send(1, ra, rb, 1'($urandom_range(0, 1)), 1'(k % 2), 1'b1);
        end
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
